// File: rtl/expr_eval_ctrl.sv
// Streaming syntax checker and evaluator for "d (op d)* =" expressions, '*' over '+'.
// Optional sticky overflow flag enabled by defining EXPR_EVAL_OVF_EN.
module expr_eval_ctrl #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         in_valid,
    input  logic [7:0]   in_char,
    output logic         in_ready,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] result,
    output logic         err,
    output logic         ovf
);
    typedef enum logic [1:0] {EXP_OPND, EXP_OP, ERR, RESULT} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] sum_q, sum_d, term_q, term_d, result_q, result_d;
    logic         mul_pend_q, mul_pend_d, err_q, err_d, in_ready_q, in_ready_d;
    logic         take, is_dig, is_add, is_mul, is_eq;
    logic [3:0]   digit;
    logic [W-1:0] prod_w, sum_w;

    assign digit  = in_char[3:0];
    assign is_dig = (in_char >= 8'h30) && (in_char <= 8'h39);
    assign is_add = (in_char == 8'h2b);
    assign is_mul = (in_char == 8'h2a);
    assign is_eq  = (in_char == 8'h3d);
    assign take   = in_valid & in_ready_q;

`ifdef EXPR_EVAL_OVF_EN
    logic [W+3:0] prod;
    logic [W:0]   sum_plus;
    logic         mul_ovf, add_ovf, ovf_q, ovf_d;
    assign prod     = {4'b0, term_q} * {{W{1'b0}}, digit};
    assign sum_plus = {1'b0, sum_q} + {1'b0, term_q};
    assign mul_ovf  = |prod[W+3:W];
    assign add_ovf  = sum_plus[W];
    assign prod_w   = prod[W-1:0];
    assign sum_w    = sum_plus[W-1:0];
    assign ovf      = ovf_q;
`else
    assign prod_w = term_q * {{(W-4){1'b0}}, digit};
    assign sum_w  = sum_q + term_q;
    assign ovf    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        term_d     = term_q;
        mul_pend_d = mul_pend_q;
        result_d   = result_q;
        err_d      = err_q;
`ifdef EXPR_EVAL_OVF_EN
        ovf_d      = ovf_q;
`endif
        case (state_q)
            EXP_OPND: if (take) begin
                if (is_dig) begin
                    term_d  = mul_pend_q ? prod_w : {{(W-4){1'b0}}, digit};
`ifdef EXPR_EVAL_OVF_EN
                    ovf_d   = ovf_q | (mul_pend_q & mul_ovf);
`endif
                    state_d = EXP_OP;
                end else if (is_eq) begin
                    result_d = '0;
                    err_d    = 1'b1;
`ifdef EXPR_EVAL_OVF_EN
                    ovf_d    = 1'b0;
`endif
                    state_d  = RESULT;
                end else begin
                    state_d = ERR;
                end
            end
            EXP_OP: if (take) begin
                if (is_add) begin
                    sum_d      = sum_w;
                    mul_pend_d = 1'b0;
`ifdef EXPR_EVAL_OVF_EN
                    ovf_d      = ovf_q | add_ovf;
`endif
                    state_d    = EXP_OPND;
                end else if (is_mul) begin
                    mul_pend_d = 1'b1;
                    state_d    = EXP_OPND;
                end else if (is_eq) begin
                    result_d = sum_w;
                    err_d    = 1'b0;
`ifdef EXPR_EVAL_OVF_EN
                    ovf_d    = ovf_q | add_ovf;
`endif
                    state_d  = RESULT;
                end else begin
                    state_d = ERR;
                end
            end
            ERR: if (take && is_eq) begin
                result_d = '0;
                err_d    = 1'b1;
`ifdef EXPR_EVAL_OVF_EN
                ovf_d    = 1'b0;
`endif
                state_d  = RESULT;
            end
            default: if (res_ready) begin
                // Handshake: start a fresh expression with clean accumulators
                sum_d      = '0;
                term_d     = '0;
                mul_pend_d = 1'b0;
                result_d   = '0;
                err_d      = 1'b0;
`ifdef EXPR_EVAL_OVF_EN
                ovf_d      = 1'b0;
`endif
                state_d    = EXP_OPND;
            end
        endcase
        in_ready_d = (state_d != RESULT);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= EXP_OPND;
            sum_q      <= '0;
            term_q     <= '0;
            mul_pend_q <= 1'b0;
            result_q   <= '0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b1;
`ifdef EXPR_EVAL_OVF_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            term_q     <= term_d;
            mul_pend_q <= mul_pend_d;
            result_q   <= result_d;
            err_q      <= err_d;
            in_ready_q <= in_ready_d;
`ifdef EXPR_EVAL_OVF_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign res_valid = (state_q == RESULT);
    assign result    = result_q;
    assign err       = err_q;
endmodule

// File: tb/tb_expr_eval_ctrl.sv
// Scoreboard bench for expr_eval_ctrl: expected results queued per expression,
// compared when the consumer handshake takes the result.
module tb_expr_eval_ctrl;
    localparam int W = 16;
`ifdef EXPR_EVAL_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         clr, in_valid, res_ready;
    logic [7:0]   in_char;
    logic         in_ready, res_valid, err, ovf;
    logic [W-1:0] result;

    typedef struct {
        logic [W-1:0] res;
        logic         e;
        logic         o;
    } exp_t;
    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    expr_eval_ctrl #(.W(W)) dut (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_char(in_char),
        .in_ready(in_ready), .res_valid(res_valid), .res_ready(res_ready),
        .result(result), .err(err), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Consumer side: sample just after the falling edge, ahead of the handshake edge
    always @(negedge clk) begin
        #1;
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_res_valid", 32'(res_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("err", 32'(err), 32'(e.e));
                chk("ovf", 32'(ovf), 32'(e.o));
            end
        end
    end

    task automatic send(input logic [7:0] c);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_char  = c;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic run_expr(input string s, input logic [W-1:0] r, input logic e, input logic o);
        exp_q.push_back('{r, e, o});
        send_str(s);
        chk({s, " latency"}, 32'(res_valid), 32'd1);
        drain();
    endtask

    initial begin
        clr = 1'b1; in_valid = 1'b0; in_char = 8'h00; res_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst res_valid", 32'(res_valid), 32'd0);
        chk("rst result", 32'(result), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst ovf", 32'(ovf), 32'd0);
        clr = 1'b0;
        @(negedge clk);

        run_expr("2+3*4=", 16'd14, 1'b0, 1'b0);
        run_expr("9*9*9*9*9=", 16'd59049, 1'b0, 1'b0);
        run_expr("9*9*9*9*9*9=", 16'd7153, 1'b0, OVF_ON);
        run_expr("5=", 16'd5, 1'b0, 1'b0);
        run_expr("9*9*9*9*9*9+=", 16'd0, 1'b1, 1'b0);
        run_expr("1++2=", 16'd0, 1'b1, 1'b0);
        run_expr("5=", 16'd5, 1'b0, 1'b0);
        run_expr("=", 16'd0, 1'b1, 1'b0);
        run_expr("5=", 16'd5, 1'b0, 1'b0);
        run_expr("12=", 16'd0, 1'b1, 1'b0);
        run_expr("5=", 16'd5, 1'b0, 1'b0);
        run_expr("4#=", 16'd0, 1'b1, 1'b0);
        run_expr("5=", 16'd5, 1'b0, 1'b0);
        run_expr("3+=", 16'd0, 1'b1, 1'b0);
        run_expr("1*2+3*4+5=", 16'd19, 1'b0, 1'b0);

        // Backpressure: result held while the consumer stalls, input refused
        res_ready = 1'b0;
        exp_q.push_back('{16'd56, 1'b0, 1'b0});
        send_str("7*8=");
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_char  = 8'h39;
            @(negedge clk);
            chk("bp res_valid", 32'(res_valid), 32'd1);
            chk("bp result", 32'(result), 32'd56);
            chk("bp in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp release in_ready", 32'(in_ready), 32'd1);
        chk("bp release res_valid", 32'(res_valid), 32'd0);
        chk("bp drained", 32'(exp_q.size()), 32'd0);
        run_expr("5=", 16'd5, 1'b0, 1'b0);

        // Asynchronous abort mid-expression
        send_str("3*4+");
        #2 clr = 1'b1;
        #1;
        chk("clr in_ready", 32'(in_ready), 32'd1);
        chk("clr res_valid", 32'(res_valid), 32'd0);
        chk("clr result", 32'(result), 32'd0);
        chk("clr err", 32'(err), 32'd0);
        chk("clr ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        run_expr("1+1=", 16'd2, 1'b0, 1'b0);

        // Idle gaps between characters
        exp_q.push_back('{16'd7, 1'b0, 1'b0});
        send(8'h36);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("gap in_ready", 32'(in_ready), 32'd1);
            chk("gap res_valid", 32'(res_valid), 32'd0);
        end
        send_str("+1=");
        chk("gap latency", 32'(res_valid), 32'd1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/expr_eval_ctrl.md
Name: expr_eval_ctrl

Overview:
- Streaming controller that accepts an ASCII character stream, one character per handshake.
- Checks expression syntax: operand (op operand)* followed by '=' terminator. Operands are single digits '0'-'9'; ops are '+' and '*'.
- Evaluates the expression with '*' binding tighter than '+', then presents the result or an error on an output handshake.
- Sits between the character source (UART/keyboard front end) and the result consumer. It replaces the bare acceptor with a full sequencer.

Parameters:
- W, 16, width of the result and internal arithmetic registers (min 4); all arithmetic is modulo 2^W.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- in_valid  in  1  character present on in_char.
- in_char  in  8  ASCII character.
- in_ready  out  1  controller can accept a character this cycle.
- res_valid  out  1  result/error pending.
- res_ready  in  1  consumer takes the result.
- result  out  W  expression value; 0 when err=1.
- err  out  1  syntax error flag, qualified by res_valid.
- ovf  out  1  arithmetic overflow flag, qualified by res_valid (see Optional Feature).

Behaviour:
- Reset values: in_ready=1, res_valid=0, result=0, err=0, ovf=0. State=EXP_OPND, sum=0, term=0, mul_pend=0.
- Character classes: DIG ('0'-'9', value = in_char-8'h30), ADD ('+'), MUL ('*'), EQ ('='), OTHER (everything else).
- A character is consumed when in_valid & in_ready at the rising edge. Exactly one character is consumed per cycle at most.
- in_ready=1 in every state except RESULT. It is registered and drops the cycle after EQ is consumed.
- States and transitions on a consumed character:
  - EXP_OPND: expects an operand (start of expression, or after an op).
    - DIG: if mul_pend, term<=term*d; else term<=d. Then -> EXP_OP.
    - EQ, ADD, MUL, OTHER -> ERR (EQ goes straight to RESULT with err=1).
  - EXP_OP: expects an op or '='.
    - ADD: sum<=sum+term, mul_pend<=0, -> EXP_OPND.
    - MUL: mul_pend<=1, -> EXP_OPND.
    - EQ: result<=sum+term, err<=0, -> RESULT.
    - DIG, OTHER -> ERR.
  - ERR: absorbs all characters except EQ. EQ: result<=0, err<=1, -> RESULT.
  - RESULT: res_valid=1, in_ready=0. result/err/ovf are held stable until res_ready=1. On handshake: res_valid<=0, sum/term/mul_pend/ovf cleared, -> EXP_OPND; in_ready=1 the next cycle.
- Latency: res_valid rises the cycle after EQ is consumed. Minimum one idle input cycle between expressions (the RESULT handshake cycle).
- Arithmetic: term*d uses a W x 4 multiply truncated to W bits; sum+term is truncated to W bits.
- No input is lost under backpressure: in_ready low means the source must hold in_char/in_valid.
- clr mid-expression or during RESULT aborts immediately. Everything returns to reset values; any partial expression is discarded and no res_valid is emitted.
- in_valid=0 cycles: no state change in any state.
- The empty expression "=" -> err=1. A trailing op before '=' ("3+=") -> err=1.

Optional Feature:
- Macro EXPR_EVAL_OVF_EN.
- Defined:
  - ovf is a sticky flag set when any multiply or add result exceeds 2^W-1.
  - It is cleared at reset and on the RESULT handshake, and reported with the result.
  - On an error expression, ovf=0.
- Undefined: ovf tied to 0; overflow wraps silently; no extra flops.

Test Plan:
- Precedence: "2+3*4=" with res_ready=1 -> res_valid one cycle after '=', result=14, err=0, ovf=0.
- Chain multiply: "9*9*9*9*9=", W=16 -> result=59049, ovf=0. Same with W=8 -> result=59049 mod 256=169; ovf=1 only with EXPR_EVAL_OVF_EN.
- Syntax errors:
  - "1++2=" -> err=1, result=0.
  - "=" -> err=1.
  - "12=" -> err=1.
  - "4#=" -> err=1.
  - After each, "5=" -> result=5, err=0.
- Backpressure: "7*8=" then hold res_ready=0 for 5 cycles -> res_valid and result=56 stable, in_ready=0, characters offered are not consumed. res_ready=1 -> in_ready=1 the next cycle.
- Reset mid-operation: "3*4+" then pulse clr asynchronously -> all outputs 0, in_ready=1. Then "1+1=" -> result=2.
- Idle gaps: "6", 3 cycles with in_valid=0, "+", "1", "=" -> result=7; no state change during the gaps.
